// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and anode helper for the segment scan driver
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// rtl/seg_prescaler.sv - free-running divider producing a one-cycle tick every REFRESH_DIV clocks
module seg_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Disabled counter sits at zero so a re-enable starts a full slot.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = en && (div_cnt_q == LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit BCD scan multiplexer with shadowed updates and digit blanking
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        upd_pending,
    output logic        err
);

    logic        tick;
    logic        boundary;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q, pend_d;
    logic        upd_q, upd_d;
    logic        started_q, started_d;

    logic [NUM_DIGITS-1:0] invalid;
    logic [NUM_DIGITS-1:0] lz;
    logic [NUM_DIGITS-1:0] blank;
    bcd_t                  cur_nib;

    bcd_t        bcd_out_q;
    logic [3:0]  an_q;
    logic [1:0]  digit_sel_q;
    logic        err_q;

    seg_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    assign boundary = tick && (idx_q == 2'd3);

    always_comb begin
        idx_d     = en ? (tick ? idx_q + 2'd1 : idx_q) : 2'd0;
        started_d = started_q | tick;
        disp_d    = disp_q;
        pend_d    = pend_q;
        upd_d     = upd_q;
        // Nothing is being scanned yet, or we sit on the frame edge: no tearing risk.
        if (load && (!en || !started_q || boundary)) begin
            disp_d = bcd_in;
            upd_d  = 1'b0;
        end else if (load) begin
            pend_d = bcd_in;
            upd_d  = 1'b1;
        end else if (boundary && upd_q) begin
            disp_d = pend_q;
            upd_d  = 1'b0;
        end
    end

    always_comb begin
        invalid = '0;
        lz      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            invalid[i] = disp_q[4*i +: 4] > 4'd9;
            lz[i]      = (i != 0) && blank_lz && ((disp_q >> (4*i)) == 16'h0000);
        end
        blank   = invalid | lz | {NUM_DIGITS{~en}};
        cur_nib = disp_q[{idx_q, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 2'd0;
            disp_q    <= 16'h0000;
            pend_q    <= 16'h0000;
            upd_q     <= 1'b0;
            started_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            upd_q     <= upd_d;
            started_q <= started_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out_q   <= 4'h0;
            an_q        <= AN_OFF;
            digit_sel_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            digit_sel_q <= idx_q;
            bcd_out_q   <= blank[idx_q] ? 4'h0 : cur_nib;
            an_q        <= blank[idx_q] ? AN_OFF : an_onehot_low(idx_q);
            err_q       <= |invalid;
        end
    end

    assign bcd_out     = bcd_out_q;
    assign an          = an_q;
    assign digit_sel   = digit_sel_q;
    assign upd_pending = upd_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized and directed checks of seg_scan_driver against a cycle-count reference model
module tb_seg_scan_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        upd_pending;
    logic        err;

    seg_scan_driver #(.REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .bcd_in      (bcd_in),
        .blank_lz    (blank_lz),
        .bcd_out     (bcd_out),
        .an          (an),
        .digit_sel   (digit_sel),
        .upd_pending (upd_pending),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: scan position is derived from the number of enabled cycles.
    int          m_cyc;
    bit          m_started;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_upd;
    logic [3:0]  e_bcd;
    logic [3:0]  e_an;
    logic [1:0]  e_sel;
    logic        e_err;
    logic        e_upd;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit digit_blank(input int i, input logic [15:0] v, input bit lzb);
        int nib;
        nib = (int'(v) >> (4*i)) & 15;
        if (nib > 9) return 1'b1;
        if (lzb && i > 0 && (int'(v) >> (4*i)) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_started = 0; m_disp = 16'h0; m_pend = 16'h0; m_upd = 0;
        e_bcd = 4'h0; e_an = 4'hF; e_sel = 2'd0; e_err = 1'b0; e_upd = 1'b0;
    endtask

    task automatic model_step();
        int idx;
        bit tick, bnd, blk;
        idx  = (m_cyc / RD) % 4;
        tick = en && (m_cyc % RD == RD - 1);
        bnd  = tick && idx == 3;
        blk  = !en || digit_blank(idx, m_disp, blank_lz);
        e_sel = 2'(idx);
        e_bcd = blk ? 4'h0 : 4'((int'(m_disp) >> (4*idx)) & 15);
        e_an  = blk ? 4'hF : 4'(15 - (1 << idx));
        e_err = 1'b0;
        for (int i = 0; i < 4; i++) if (((int'(m_disp) >> (4*i)) & 15) > 9) e_err = 1'b1;
        if (load && (!en || !m_started || bnd)) begin
            m_disp = bcd_in; m_upd = 0;
        end else if (load) begin
            m_pend = bcd_in; m_upd = 1;
        end else if (bnd && m_upd) begin
            m_disp = m_pend; m_upd = 0;
        end
        if (tick) m_started = 1;
        m_cyc = en ? m_cyc + 1 : 0;
        e_upd = m_upd;
    endtask

    task automatic check_outputs();
        check_eq("bcd_out", 16'(bcd_out), 16'(e_bcd));
        check_eq("an", 16'(an), 16'(e_an));
        check_eq("digit_sel", 16'(digit_sel), 16'(e_sel));
        check_eq("err", 16'(err), 16'(e_err));
        check_eq("upd_pending", 16'(upd_pending), 16'(e_upd));
    endtask

    task automatic cycle(input bit en_v, input bit load_v, input logic [15:0] bcd_v, input bit lz_v);
        @(negedge clk);
        check_outputs();
        rst = 1'b0; en = en_v; load = load_v; bcd_in = bcd_v; blank_lz = lz_v;
        model_step();
    endtask

    task automatic async_reset();
        @(negedge clk);
        check_outputs();
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_bcd_out", 16'(bcd_out), 16'h0);
        check_eq("rst_an", 16'(an), 16'hF);
        check_eq("rst_digit_sel", 16'(digit_sel), 16'h0);
        check_eq("rst_err", 16'(err), 16'h0);
        check_eq("rst_upd_pending", 16'(upd_pending), 16'h0);
        model_reset();
    endtask

    task automatic run(input int n, input bit lz_v);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 16'h0, lz_v);
    endtask

    task automatic run_to_idx(input int target);
        for (int k = 0; k < 64; k++) begin
            if ((m_cyc / RD) % 4 == target && m_cyc % RD == 0) break;
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        if ($urandom % 3 == 0) v = v >> (4 * $urandom_range(1, 3));
        return v;
    endfunction

    initial begin
        bit lz_r;
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0;
        model_reset();
        #1;
        check_outputs();

        cycle(1'b1, 1'b1, 16'h1234, 1'b0);
        run(36, 1'b0);

        cycle(1'b1, 1'b1, 16'h0056, 1'b1);
        run(40, 1'b1);
        run(20, 1'b0);

        cycle(1'b1, 1'b1, 16'h9999, 1'b0);
        run(20, 1'b0);
        run_to_idx(1);
        cycle(1'b1, 1'b1, 16'h0001, 1'b0);
        cycle(1'b1, 1'b1, 16'h0002, 1'b0);
        run(24, 1'b0);

        for (int k = 0; k < 64; k++) begin
            if (m_cyc % (4 * RD) == 4 * RD - 1) break;
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        run(20, 1'b0);

        cycle(1'b1, 1'b1, 16'h1A34, 1'b0);
        run(40, 1'b0);

        run_to_idx(2);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        run(10, 1'b0);
        async_reset();
        run(10, 1'b0);

        lz_r = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom % 600 == 0) async_reset();
            if ($urandom % 50 == 0) lz_r = !lz_r;
            cycle(($urandom % 20) != 0, ($urandom % 12) == 0, rand_bcd(), lz_r);
        end
        @(negedge clk);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Upstream feeder for the single-digit BCD-to-7-segment decoder, which has active-low segments and one active-low anode.
- Holds a 4-digit packed BCD value and time-multiplexes it. On each refresh tick it presents one digit's BCD nibble on bcd_out and drives the matching active-low anode on an.
- Adds tear-free updates through a shadow register, optional leading-zero blanking, and blanking of invalid nibbles. The downstream decoder therefore never renders its don't-care codes.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. 1 kHz per digit at 100 MHz. Legal range is 2 and above.
- DIV_W, $clog2(REFRESH_DIV): prescaler counter width. Derived; not overridden.

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: scan enable. 0 blanks the display and freezes the scan at digit 0.
- load, in, 1: one-cycle strobe that captures bcd_in.
- bcd_in, in, 16: packed BCD value. [15:12] is digit 3 (most significant); [3:0] is digit 0.
- blank_lz, in, 1: 1 enables leading-zero blanking.
- bcd_out, out, 4: BCD nibble for the decoder input B.
- an, out, 4: active-low anodes. an[i]=0 lights digit i.
- digit_sel, out, 2: index of the digit currently driven.
- upd_pending, out, 1: a loaded value is waiting for the frame boundary.
- err, out, 1: the displayed value contains a nibble greater than 9.

Behaviour:
- Reset (asynchronous, active-high):
  - Internal state: div_cnt=0, idx=0, disp=16'h0000, pend=16'h0000, upd_pending=0.
  - Outputs: bcd_out=4'h0, an=4'b1111, digit_sel=0, err=0.
- Prescaler:
  - When en=1, div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick = (div_cnt==REFRESH_DIV-1) & en.
  - On tick, idx <= idx+1 mod 4, wrapping 3->0.
  - When en=0, div_cnt and idx are held at 0.
- Frame boundary: the tick on which idx wraps 3->0. On that tick, if upd_pending=1, then disp <= pend and upd_pending <= 0.
- Load handling:
  - load=1 on a non-boundary cycle: pend <= bcd_in and upd_pending <= 1. A second load before commit overwrites pend (last wins).
  - load=1 on the boundary cycle itself: disp <= bcd_in directly as a bypass, and upd_pending <= 0.
- Initial fill: while en=0, or before the first tick after reset, any load commits immediately (disp <= bcd_in, upd_pending stays 0). A blank display has no tearing to avoid.
- Blank per digit i (computed from disp):
  - invalid_i = disp nibble i > 9.
  - lz_i (i = 1..3) = blank_lz & (nibbles i..3 all equal 0). Digit 0 is never lz-blanked.
  - blank_i = invalid_i | lz_i | ~en.
- Registered outputs, updated every cycle from the current idx and disp:
  - digit_sel <= idx.
  - bcd_out <= blank_idx ? 4'h0 : disp nibble idx.
  - an <= blank_idx ? 4'b1111 : ~(4'b0001 << idx).
- Latency: an and bcd_out change exactly one clock after an idx or disp change. Exactly one anode is low at a time; all anodes are high when blanked.
- err: registered; equals the OR of invalid_i over disp. Updates one cycle after disp changes.
- en deassert mid-frame: on the next cycle an=1111 and bcd_out=0, with idx and div_cnt reset to 0. pend and upd_pending are retained. On reassert, scanning restarts at digit 0.
- Reset mid-frame: all state returns immediately to the reset values.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS=4.
  - typedef bcd_t (logic [3:0]).
  - AN_OFF=4'b1111.
  - Function an_onehot_low(idx).
- Sub-module seg_prescaler (parameter REFRESH_DIV; ports clk, rst, en, tick) is natural and reusable for blink and debounce timers.
- The blank logic stays inline.

Test Plan (REFRESH_DIV=4 in the bench):
- Reset, en=1, load 16'h1234 before the first tick. Required: an cycles 1110, 1101, 1011, 0111 every 4 clocks with bcd_out 4, 3, 2, 1, and the sequence repeats.
- Load 16'h0056 at blank_lz=1. Required: digits 3 and 2 show an=1111 and bcd_out=0; digits 1 and 0 show 5 and 6. With blank_lz=0, digits 3 and 2 show 0 with their anodes low.
- Load 16'h9999, then mid-frame at idx=1 load 16'h0001 and then 16'h0002. Required: upd_pending=1 and 9s continue until the 3->0 wrap. Digit 0 of the next frame shows 2 and upd_pending drops to 0.
- Load on the exact boundary tick. Required: the new value is shown at digit 0 on the very next cycle, and upd_pending stays 0.
- Load 16'h1A34. Required: err=1 one cycle after commit, and digit 2 has an=1111 and bcd_out=0. The other digits display normally.
- Drop en at idx=2. Required: next cycle an=1111. On re-enable, digit 0 is driven first. Then assert rst asynchronously mid-count. Required: outputs go to reset values immediately, without waiting for a clock edge.
